data_mem_mmio: RTL and testbench

//  M-stage data-memory subsystem for the pipelined core; sits directly downstream of the CPU's

---
 rtl/data_mem_mmio_if.sv | 23 ++
 rtl/data_mem_mmio.sv | 149 ++++++++++++++
 tb/tb_data_mem_mmio.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_mmio_if.sv
// Data-port bundle between the M-stage of the core and the data-memory
// subsystem, plus the TX byte drain port (ready/valid).
interface data_mem_mmio_if;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // Core side: issues accesses and consumes drained bytes.
  modport master (
    output MemWriteM, ALUOutM, WriteDataM, tx_ready,
    input  ReadDataM, tx_data, tx_valid
  );

  // Memory side: decodes accesses and sources the TX byte stream.
  modport slave (
    input  MemWriteM, ALUOutM, WriteDataM, tx_ready,
    output ReadDataM, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_mmio.sv
// M-stage data memory: word RAM from address 0 plus a 16-byte MMIO window
// holding a TX byte FIFO, a free-running cycle counter and a scratch register.
// Loads are combinational so the core captures them into W without stalling.
module data_mem_mmio #(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic            clk,
  input  logic            reset,   // active-low, asynchronous
  data_mem_mmio_if.slave  memBus
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // ---------------------------------------------------------------- decode
  logic [31:0]       wordAddr;
  logic              isRam;
  logic              inWindow;
  logic              selTx;
  logic              selStatus;
  logic              selCycle;
  logic              selScratch;
  logic [RAM_AW-1:0] ramIdx;

  assign wordAddr   = memBus.ALUOutM & ~32'h3;
  assign isRam      = wordAddr < 32'(RAM_WORDS * 4);
  assign ramIdx     = wordAddr[RAM_AW+1:2];
  assign inWindow   = wordAddr[31:4] == MMIO_BASE[31:4];
  assign selTx      = inWindow && (wordAddr[3:2] == 2'd0);
  assign selStatus  = inWindow && (wordAddr[3:2] == 2'd1);
  assign selCycle   = inWindow && (wordAddr[3:2] == 2'd2);
  assign selScratch = inWindow && (wordAddr[3:2] == 2'd3);

  // ---------------------------------------------------------------- state
  logic [31:0]      ram [RAM_WORDS];
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic [CNT_W-1:0] countNext;
  logic             ovfReg;
  logic             ovfNext;
  logic [31:0]      cycleReg;
  logic [31:0]      scratchReg;

  logic fifoFull;
  logic fifoEmpty;
  logic pushReq;
  logic doPush;
  logic doPop;

  assign fifoFull  = countReg == CNT_W'(FIFO_DEPTH);
  assign fifoEmpty = countReg == '0;
  assign pushReq   = memBus.MemWriteM && selTx;
  assign doPop     = !fifoEmpty && memBus.tx_ready;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign doPush    = pushReq && (!fifoFull || doPop);

  assign memBus.tx_valid = !fifoEmpty;
  assign memBus.tx_data  = fifoMem[rdPtrReg];

  // Next occupancy and sticky overflow flag (W1C through STATUS bit 2).
  always_comb begin
    countNext = countReg;
    case ({doPush, doPop})
      2'b10:   countNext = countReg + CNT_W'(1);
      2'b01:   countNext = countReg - CNT_W'(1);
      default: countNext = countReg;
    endcase
    ovfNext = ovfReg;
    if (pushReq && fifoFull && !doPop) begin
      ovfNext = 1'b1;
    end else if (memBus.MemWriteM && selStatus && memBus.WriteDataM[2]) begin
      ovfNext = 1'b0;
    end
  end

  // RAM store port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (memBus.MemWriteM && isRam) begin
      ram[ramIdx] <= memBus.WriteDataM;
    end
  end

  // FIFO byte storage; stale entries are harmless since tx_valid gates them.
  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoMem[wrPtrReg] <= memBus.WriteDataM[7:0];
    end
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      ovfReg   <= 1'b0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (doPop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      countReg <= countNext;
      ovfReg   <= ovfNext;
    end
  end

  // Free-running cycle counter; any write reloads zero at that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleReg <= '0;
    end else if (memBus.MemWriteM && selCycle) begin
      cycleReg <= '0;
    end else begin
      cycleReg <= cycleReg + 32'd1;
    end
  end

  // Scratch register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scratchReg <= '0;
    end else if (memBus.MemWriteM && selScratch) begin
      scratchReg <= memBus.WriteDataM;
    end
  end

  // ---------------------------------------------------------------- read mux
  // STATUS layout: count in [7:4], bit 3 reads zero, ovf/empty/full in [2:0].
  logic [3:0] countNib;
  assign countNib = 4'(countReg);

  // Side-effect-free combinational load path.
  always_comb begin
    memBus.ReadDataM = 32'h0;
    if (isRam) begin
      memBus.ReadDataM = ram[ramIdx];
    end else if (selStatus) begin
      memBus.ReadDataM = {24'h0, countNib, 1'b0, ovfReg, fifoEmpty, fifoFull};
    end else if (selCycle) begin
      memBus.ReadDataM = cycleReg;
    end else if (selScratch) begin
      memBus.ReadDataM = scratchReg;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: a queue-based reference model is checked
// every cycle, and directed steps pin literal expected values.
module tb_data_mem_mmio;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STS  = BASE + 32'h4;
  localparam logic [31:0] CYC  = BASE + 32'h8;
  localparam logic [31:0] SCR  = BASE + 32'hC;
  localparam logic [31:0] IDLE = 32'h0000_2000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_mem_mmio_if bus();

  data_mem_mmio #(.RAM_WORDS(256), .FIFO_DEPTH(8), .MMIO_BASE(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .memBus(bus)
  );

  int compared = 0;
  int mismatched = 0;

  // ------------------------------------------------ reference model
  logic [31:0] mRam [256];
  bit          mRamOk [256];
  logic [7:0]  mQ [$];
  bit          mOvf;
  logic [31:0] mCycle;
  logic [31:0] mScratch;
  logic [7:0]  drainLog [$];
  logic [31:0] mW;
  bit          mPop;
  bit          mFull;

  function automatic logic [31:0] mRead(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w < 32'd1024) return mRam[w[9:2]];
    if (w == STS) return {24'h0, 4'(mQ.size()), 1'b0, mOvf, mQ.size() == 0, mQ.size() == 8};
    if (w == CYC) return mCycle;
    if (w == SCR) return mScratch;
    return 32'h0;
  endfunction

  function automatic bit mKnown(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w < 32'd1024) return mRamOk[w[9:2]];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mQ.delete();
      mOvf = 1'b0;
      mCycle = 32'h0;
      mScratch = 32'h0;
    end else begin
      mW = bus.ALUOutM & ~32'h3;
      mPop = (mQ.size() > 0) && bus.tx_ready;
      mFull = (mQ.size() == 8);
      if (mPop) drainLog.push_back(mQ.pop_front());
      mCycle = mCycle + 32'd1;
      if (bus.MemWriteM) begin
        if (mW < 32'd1024) begin
          mRam[mW[9:2]] = bus.WriteDataM;
          mRamOk[mW[9:2]] = 1'b1;
        end else if (mW == TXD) begin
          if (mFull && !mPop) mOvf = 1'b1;
          else mQ.push_back(bus.WriteDataM[7:0]);
        end else if (mW == STS) begin
          if (bus.WriteDataM[2]) mOvf = 1'b0;
        end else if (mW == CYC) begin
          mCycle = 32'h0;
        end else if (mW == SCR) begin
          mScratch = bus.WriteDataM;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("tx_valid", 32'(bus.tx_valid), 32'(mQ.size() != 0));
      if (mQ.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(mQ[0]));
      if (mKnown(bus.ALUOutM)) chk("ReadDataM", bus.ReadDataM, mRead(bus.ALUOutM));
    end
  end

  // ------------------------------------------------ directed stimulus
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.ALUOutM = a;
    bus.WriteDataM = d;
    bus.MemWriteM = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWriteM = 1'b0;
    bus.ALUOutM = IDLE;
    $display("wr  %h <= %h", a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.ALUOutM = a;
    @(negedge clk);
    chk(name, bus.ReadDataM, exp);
    $display("rd  %h -> %h (%s)", a, bus.ReadDataM, name);
    @(posedge clk);
    #1;
    bus.ALUOutM = IDLE;
  endtask

  task automatic sampleCycle(output logic [31:0] v);
    bus.ALUOutM = CYC;
    @(negedge clk);
    v = bus.ReadDataM;
    $display("rd  %h -> %h (cycle sample)", CYC, v);
    @(posedge clk);
    #1;
    bus.ALUOutM = IDLE;
  endtask

  task automatic checkValid(input logic exp, input string name);
    @(negedge clk);
    chk(name, 32'(bus.tx_valid), 32'(exp));
    $display("chk tx_valid=%0b (%s)", bus.tx_valid, name);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] c1;
  logic [31:0] c2;

  initial begin
    bus.MemWriteM = 1'b0;
    bus.ALUOutM = IDLE;
    bus.WriteDataM = 32'h0;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    rd(CYC, 32'h0, "rst_cycle");
    rd(STS, 32'h02, "rst_status");
    rd(SCR, 32'h0, "rst_scratch");
    rd(IDLE, 32'h0, "rst_unmapped");
    checkValid(1'b0, "rst_txvalid");

    // T1 RAM, including byte-offset alias and last word / first unmapped
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10, 32'hDEADBEEF, "t1_ram");
    rd(32'h13, 32'hDEADBEEF, "t1_ram_offset");
    wr(32'h3FC, 32'h1234_5678);
    rd(32'h3FC, 32'h1234_5678, "t1_ram_last");
    rd(32'h400, 32'h0, "t1_past_ram");

    // T2 FIFO ordering
    wr(TXD, 32'h41);
    wr(TXD, 32'h42);
    wr(TXD, 32'h43);
    rd(STS, 32'h30, "t2_status3");
    drainLog.delete();
    bus.tx_ready = 1'b1;
    idle(3);
    bus.tx_ready = 1'b0;
    chk("t2_drain_n", 32'(drainLog.size()), 32'd3);
    chk("t2_drain0", 32'(drainLog[0]), 32'h41);
    chk("t2_drain1", 32'(drainLog[1]), 32'h42);
    chk("t2_drain2", 32'(drainLog[2]), 32'h43);
    rd(STS, 32'h02, "t2_status_empty");
    checkValid(1'b0, "t2_txvalid");

    // T3 overflow and W1C
    for (int i = 0; i < 9; i++) wr(TXD, 32'h60 + 32'(i));
    rd(STS, 32'h85, "t3_status_ovf");
    wr(STS, 32'h4);
    rd(STS, 32'h81, "t3_status_w1c");

    // T4 full FIFO with simultaneous pop and push
    drainLog.delete();
    bus.tx_ready = 1'b1;
    wr(TXD, 32'h55);
    bus.tx_ready = 1'b0;
    rd(STS, 32'h81, "t4_status_full");
    bus.tx_ready = 1'b1;
    idle(8);
    bus.tx_ready = 1'b0;
    chk("t4_drain_n", 32'(drainLog.size()), 32'd9);
    chk("t4_drain_first", 32'(drainLog[0]), 32'h60);
    chk("t4_drain_7", 32'(drainLog[7]), 32'h67);
    chk("t4_drain_last", 32'(drainLog[8]), 32'h55);
    checkValid(1'b0, "t4_txvalid");

    // T5 cycle counter
    sampleCycle(c1);
    idle(9);
    sampleCycle(c2);
    chk("t5_delta", c2 - c1, 32'd10);
    wr(CYC, 32'h0000_0123);
    rd(CYC, 32'h0, "t5_cleared");
    rd(CYC, 32'h1, "t5_resumed");

    // Scratch and ignored writes to unmapped space
    wr(SCR, 32'hCAFE_F00D);
    rd(SCR, 32'hCAFE_F00D, "scratch_rw");
    wr(IDLE, 32'hFFFF_FFFF);
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    rd(SCR, 32'hCAFE_F00D, "scratch_kept");
    rd(STS, 32'h02, "status_kept");
    rd(IDLE, 32'h0, "unmapped_read");

    // T6 reset in the middle of a drain
    wr(TXD, 32'hA1);
    wr(TXD, 32'hA2);
    wr(TXD, 32'hA3);
    wr(TXD, 32'hA4);
    bus.tx_ready = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    bus.tx_ready = 1'b0;
    checkValid(1'b0, "t6_txvalid");
    rd(STS, 32'h02, "t6_status");
    rd(SCR, 32'h0, "t6_scratch");
    rd(IDLE, 32'h0, "t6_unmapped");
    rd(32'h10, 32'hDEADBEEF, "t6_ram_kept");

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
